dac_spi_multi: RTL and testbench

- Parametrised successor to the single-channel DAC SPI driver.
- Accepts {channel, sample} writes from GPO-driven logic through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each entry as a 16-bit frame on a shared sclk/dac_din bus, with one active-low sync (chip-select) per DAC channel.
- Sits between the MicroBlaze GPO registers and the Pmod DAC connectors, clocked from clk_10MHz.

---
 rtl/dac_spi_multi.sv | 173 +++++++++++++++++
 tb/tb_dac_spi_multi.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_multi.sv
// Multi-channel DAC SPI driver: {channel, sample} FIFO feeding a shared sclk/din bus with per-channel sync.
// Define DAC_SPI_BROADCAST_EN to treat an all-ones channel as a broadcast to every DAC.
module dac_spi_multi #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_HP     = 2,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              sclk,
  output logic              dac_din,
  output logic [NUM_CH-1:0] sync,
  output logic              busy,
  output logic              err,
  output logic [LVL_W-1:0]  fifo_level
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HP_W  = $clog2(((GAP_HP > 32) ? GAP_HP : 32) + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [HP_W-1:0]     hp_q, hp_d;
  logic                sclk_q, sclk_d;
  logic                din_q, din_d;
  logic [NUM_CH-1:0]   sync_q, sync_d;
  logic [14:0]         sh_q, sh_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CH_W+DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic              full, hs, push, pop, bad, tick, in_range, is_bcast;
  logic [CH_W-1:0]   rd_ch;
  logic [DATA_W-1:0] rd_data;
  logic [15:0]       frame_w;
  logic [NUM_CH-1:0] sel;

`ifdef DAC_SPI_BROADCAST_EN
  assign is_bcast = &wr_ch;
`else
  assign is_bcast = 1'b0;
`endif

  assign full     = (level_q == LVL_W'(FIFO_DEPTH));
  assign wr_ready = !full;
  assign in_range = (32'(wr_ch) < NUM_CH);
  assign hs       = wr_valid && wr_ready;
  assign push     = hs && (in_range || is_bcast);
  assign bad      = hs && !in_range && !is_bcast;
  assign pop      = (state_q == IDLE) && (level_q != '0);
  assign tick     = (state_q != IDLE) && (div_q == DIV_W'(CLK_DIV - 1));

  assign {rd_ch, rd_data} = mem_q[rd_ptr_q];
  // Control nibble is all zero (normal power-down mode); sample left-justified in 12 bits.
  assign frame_w = {4'b0000, 12'(rd_data) << (12 - DATA_W)};

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++) sel[i] = (rd_ch == CH_W'(i));
`ifdef DAC_SPI_BROADCAST_EN
    if (&rd_ch) sel = '1;
`endif
  end

  always_ff @(posedge clk_in)
    if (push) mem_q[wr_ptr_q] <= {wr_ch, wr_data};

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    busy_d   = (state_q != IDLE) || (level_q != '0);
    err_d    = bad;
    state_d  = state_q;
    div_d    = div_q;
    hp_d     = hp_q;
    sclk_d   = sclk_q;
    din_d    = din_q;
    sync_d   = sync_q;
    sh_d     = sh_q;
    if (state_q != IDLE) div_d = tick ? '0 : div_q + 1'b1;
    case (state_q)
      IDLE: begin
        div_d  = '0;
        hp_d   = '0;
        sclk_d = 1'b1;
        din_d  = 1'b0;
        sync_d = '1;
        if (pop) begin
          state_d = LOAD;
          sync_d  = ~sel;
          sh_d    = frame_w[14:0];
          din_d   = frame_w[15];
        end
      end
      LOAD: if (tick) begin
        state_d = SHIFT;
        sclk_d  = 1'b0;
        hp_d    = '0;
      end
      SHIFT: if (tick) begin
        if (hp_q == HP_W'(31)) begin
          state_d = GAP;
          sclk_d  = 1'b1;
          sync_d  = '1;
          din_d   = 1'b0;
          hp_d    = '0;
        end else begin
          hp_d   = hp_q + 1'b1;
          sclk_d = ~sclk_q;
          // Advance data on rising sclk; the 16th rise has no bit left to present.
          if (!sclk_q && hp_q != HP_W'(30)) begin
            din_d = sh_q[14];
            sh_d  = {sh_q[13:0], 1'b0};
          end
        end
      end
      GAP: if (tick) begin
        if (hp_q == HP_W'(GAP_HP - 1)) state_d = IDLE;
        else hp_d = hp_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst)
    if (!rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      hp_q     <= '0;
      sclk_q   <= 1'b1;
      din_q    <= 1'b0;
      sync_q   <= '1;
      sh_q     <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      hp_q     <= hp_d;
      sclk_q   <= sclk_d;
      din_q    <= din_d;
      sync_q   <= sync_d;
      sh_q     <= sh_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end

  assign sclk       = sclk_q;
  assign dac_din    = din_q;
  assign sync       = sync_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign fifo_level = level_q;
endmodule

// File: tb/tb_dac_spi_multi.sv
// Randomised bench for dac_spi_multi: a queue model of accepted writes is compared
// against frames decoded from the serial bus.
module tb_dac_spi_multi;
  localparam int NUM_CH = 3, DATA_W = 8, CLK_DIV = 2, FIFO_DEPTH = 4, GAP_HP = 2;
  localparam int CH_W = 2, LVL_W = 3;
  localparam logic [NUM_CH-1:0] ALL1 = '1;

  logic              clk_in = 1'b0, rst = 1'b1;
  logic [DATA_W-1:0] wr_data = '0;
  logic [CH_W-1:0]   wr_ch = '0;
  logic              wr_valid = 1'b0;
  logic              wr_ready, sclk, dac_din, busy, err;
  logic [NUM_CH-1:0] sync;
  logic [LVL_W-1:0]  fifo_level;

  dac_spi_multi #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV),
                  .FIFO_DEPTH(FIFO_DEPTH), .GAP_HP(GAP_HP)) dut (
    .clk_in(clk_in), .rst(rst), .wr_data(wr_data), .wr_ch(wr_ch), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .sclk(sclk), .dac_din(dac_din), .sync(sync), .busy(busy),
    .err(err), .fifo_level(fifo_level));

  always #5 clk_in = ~clk_in;

  typedef struct { int sync; int word; } exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  int pushes_m = 0, starts = 0, cyc = 0, last_start = 0;
  int frm_len, nfall, word, peak = 0, errs = 0;
  bit err_exp = 0, in_frame = 0, prev_sclk = 1, expect_next = 0, sync_bad = 0, saw_full = 0;
  logic [NUM_CH-1:0] frm_sync;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: accepted writes become expected frames in order.
  always @(posedge clk_in) begin
    if (!rst) begin
      pushes_m = 0; exp_q.delete(); err_exp = 0;
    end else begin
      bit acc, bc, ok;
      int ch;
      exp_t e;
      acc = wr_valid && ((pushes_m - starts) < FIFO_DEPTH);
      ch  = int'(wr_ch);
      bc  = 0;
`ifdef DAC_SPI_BROADCAST_EN
      bc  = (ch == (1 << CH_W) - 1);
`endif
      ok  = bc || (ch < NUM_CH);
      err_exp = acc && !ok;
      if (acc && ok) begin
        e.word = int'(wr_data) * (1 << (12 - DATA_W));
        e.sync = bc ? 0 : (((1 << NUM_CH) - 1) & ~(1 << ch));
        exp_q.push_back(e);
        pushes_m++;
      end
    end
  end

  // Bus monitor: decodes frames and checks per-cycle status outputs.
  always @(negedge clk_in) begin
    cyc++;
    if (!rst) begin
      in_frame = 0; starts = 0; prev_sclk = 1; expect_next = 0;
    end else begin
      if (!in_frame && sync != ALL1) begin
        chk("start_has_entry", pushes_m > starts, 1);
        if (expect_next) chk("start_spacing", cyc - last_start, (33 + GAP_HP) * CLK_DIV + 1);
        in_frame = 1; frm_sync = sync; frm_len = 0; nfall = 0; word = 0; sync_bad = 0;
        starts++; expect_next = 0; last_start = cyc;
      end
      if (in_frame && sync != ALL1) begin
        frm_len++;
        if (sync != frm_sync) sync_bad = 1;
        if (prev_sclk && !sclk) begin word = (word << 1) | int'(dac_din); nfall++; end
      end else if (in_frame) begin
        in_frame = 0;
        chk("frame_len", frm_len, 33 * CLK_DIV);
        chk("frame_falls", nfall, 16);
        chk("sync_stable", sync_bad, 0);
        if (exp_q.size() > 0) begin
          chk("frame_word", word, exp_q[0].word);
          chk("frame_sync", frm_sync, exp_q[0].sync);
          void'(exp_q.pop_front());
        end
        expect_next = (pushes_m - starts) > 0;
      end
      if (!in_frame) chk("idle_bus", {sclk, dac_din}, 2'b10);
      chk("fifo_level", fifo_level, pushes_m - starts);
      chk("wr_ready", wr_ready, (pushes_m - starts) < FIFO_DEPTH);
      chk("err", err, err_exp);
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      if (!wr_ready) saw_full = 1;
      if (err) errs++;
      prev_sclk = sclk;
    end
  end

  task automatic send(input int ch, input int d);
    int n = 0;
    wr_valid = 1'b1; wr_ch = CH_W'(ch); wr_data = DATA_W'(d);
    while (!wr_ready && n < 2000) begin @(negedge clk_in); n++; end
    chk("send_timeout", n < 2000, 1);
    @(negedge clk_in);
    wr_valid = 1'b0;
  endtask

  task automatic wait_sync(input bit low);
    int n = 0;
    while (((sync != ALL1) != low) && n < 3000) begin @(negedge clk_in); n++; end
    chk("wait_sync_timeout", n < 3000, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || in_frame || pushes_m != starts) && n < 6000) begin @(negedge clk_in); n++; end
    chk("drain_timeout", n < 6000, 1);
  endtask

  initial begin
    int n;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk_in);
    #1;
    chk("rst_sync", sync, ALL1);
    chk("rst_sclk", sclk, 1);
    chk("rst_din", dac_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", wr_ready, 1);
    #1 rst = 1'b1;
    @(negedge clk_in);

    // Single frame: ch1 0xA5 -> 0x0A50, then busy tail
    send(1, 'hA5);
    wait_sync(1);
    wait_sync(0);
    n = 0;
    while (busy && n < 20) begin @(negedge clk_in); n++; end
    chk("busy_tail", n, 5);
    drain();

    // Back-to-back frames
    send(0, 'h00);
    send(1, 'hFF);
    drain();

    // Overfill: peak occupancy and a held write
    peak = 0; saw_full = 0;
    for (int i = 0; i < 6; i++) send(i % 3, 'h11 * (i + 1));
    drain();
    chk("peak_level", peak, FIFO_DEPTH);
    chk("saw_not_ready", saw_full, 1);

    // Highest legal channel, then an out-of-range (or broadcast) channel
    errs = 0;
    send(2, 'h3C);
    send(3, 'h80);
    drain();
`ifdef DAC_SPI_BROADCAST_EN
    chk("err_pulses", errs, 0);
`else
    chk("err_pulses", errs, 1);
`endif

    // Reset in mid-frame
    send(0, 'h77);
    wait_sync(1);
    repeat (29) @(negedge clk_in);
    #2 rst = 1'b0;
    #1;
    chk("midrst_sync", sync, ALL1);
    chk("midrst_sclk", sclk, 1);
    chk("midrst_din", dac_din, 0);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_busy", busy, 0);
    repeat (2) @(negedge clk_in);
    #2 rst = 1'b1;
    repeat (150) @(negedge clk_in);
    chk("no_frame_after_rst", starts, 0);
    chk("idle_after_rst", sync, ALL1);

    // Random traffic
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 90)) @(negedge clk_in);
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
    end
    drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
